// File: rtl/shift_reg_sahr.sv
// Purpose : WIDTH-bit universal register supporting load, shift, rotate and
//           arithmetic shift, plus a multi-step "shift by N" command.
// Latency : a direct op is visible 1 cycle after its edge. An N-step op
//           finishes N enabled edges after the start edge; done pulses the
//           cycle after the last step.
// Backpressure: en=0 stalls a run without losing state. start and mode are
//           ignored while busy, and clr aborts a run.
//
// Ports:
//   clk, rst         rising-edge clock; asynchronous active-high reset
//   en               clock enable for direct ops and run steps
//   clr              synchronous clear (aborts any run, no done)
//   mode[2:0]        000 hold, 001 load, 010 shr, 011 shl, 100 ror,
//                    101 rol, 110 asr, 111 hold
//   d                parallel load data
//   ser_in_msb/lsb   serial bits entering on shift right / shift left
//   start, amount    launch a multi-step op of type mode, amount steps
//   q                register contents
//   ser_out_msb/lsb  q[WIDTH-1] / q[0]
//   busy, done       run in progress / one-cycle completion pulse
module shift_reg_sahr #(
    parameter int                 WIDTH     = 8,
    parameter logic [WIDTH-1:0]   RESET_VAL = '0
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         en,
    input  logic                         clr,
    input  logic [2:0]                   mode,
    input  logic [WIDTH-1:0]             d,
    input  logic                         ser_in_msb,
    input  logic                         ser_in_lsb,
    input  logic                         start,
    input  logic [$clog2(WIDTH+1)-1:0]   amount,
    output logic [WIDTH-1:0]             q,
    output logic                         ser_out_msb,
    output logic                         ser_out_lsb,
    output logic                         busy,
    output logic                         done
);

    localparam int             AW    = $clog2(WIDTH + 1);
    localparam logic [AW-1:0]  W_CNT = AW'(WIDTH);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t            state_q, state_d;
    logic [WIDTH-1:0]  q_q, q_d;
    logic [2:0]        op_q, op_d;
    logic [AW-1:0]     cnt_q, cnt_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;

    logic              start_multi;
    logic [AW-1:0]     amt_clamped;

    // One application of an operation to the current register value.
    function automatic logic [WIDTH-1:0] apply_op(
        input logic [2:0]        op,
        input logic [WIDTH-1:0]  v,
        input logic              si_msb,
        input logic              si_lsb
    );
        logic [WIDTH-1:0] r;
        case (op)
            3'b001:  r = d;
            3'b010:  r = {si_msb, v[WIDTH-1:1]};
            3'b011:  r = {v[WIDTH-2:0], si_lsb};
            3'b100:  r = {v[0], v[WIDTH-1:1]};
            3'b101:  r = {v[WIDTH-2:0], v[WIDTH-1]};
            3'b110:  r = {v[WIDTH-1], v[WIDTH-1:1]};
            default: r = v;
        endcase
        return r;
    endfunction

    // Only the shift/rotate family runs as a multi-step op; other modes
    // given with start fall through to the direct-op path.
    assign start_multi = start && (mode >= 3'b010) && (mode <= 3'b110);
    assign amt_clamped = (amount > W_CNT) ? W_CNT : amount;

    always_comb begin
        state_d = state_q;
        q_d     = q_q;
        op_d    = op_q;
        cnt_d   = cnt_q;
        busy_d  = busy_q;
        done_d  = 1'b0;

        if (clr) begin
            state_d = IDLE;
            q_d     = RESET_VAL;
            cnt_d   = '0;
            busy_d  = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start_multi) begin
                        op_d  = mode;
                        cnt_d = amt_clamped;
                        if (amt_clamped == '0) begin
                            done_d = 1'b1;
                        end else begin
                            busy_d  = 1'b1;
                            state_d = RUN;
                        end
                    end else if (en) begin
                        q_d = apply_op(mode, q_q, ser_in_msb, ser_in_lsb);
                    end
                end
                RUN: begin
                    if (en) begin
                        q_d   = apply_op(op_q, q_q, ser_in_msb, ser_in_lsb);
                        cnt_d = cnt_q - AW'(1);
                        if (cnt_q == AW'(1)) begin
                            busy_d  = 1'b0;
                            done_d  = 1'b1;
                            state_d = IDLE;
                        end
                    end
                end
                default: begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            q_q     <= RESET_VAL;
            op_q    <= 3'b000;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            q_q     <= q_d;
            op_q    <= op_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign q           = q_q;
    assign ser_out_msb = q_q[WIDTH-1];
    assign ser_out_lsb = q_q[0];
    assign busy        = busy_q;
    assign done        = done_q;

endmodule

// File: tb/tb_shift_reg_sahr.sv
// Purpose : directed bench for shift_reg_sahr (WIDTH=8, RESET_VAL=0).
// Latency : expectations are queued when a step is driven and checked 1ns
//           after the following rising edge (or immediately for async reset).
// Backpressure: none; the bench drives every cycle.
module tb_shift_reg_sahr;

    logic        clk;
    logic        rst;
    logic        en;
    logic        clr;
    logic [2:0]  mode;
    logic [7:0]  d;
    logic        ser_in_msb;
    logic        ser_in_lsb;
    logic        start;
    logic [3:0]  amount;
    logic [7:0]  q;
    logic        ser_out_msb;
    logic        ser_out_lsb;
    logic        busy;
    logic        done;

    typedef struct {
        string      tag;
        logic [7:0] q;
        logic       busy;
        logic       done;
    } exp_t;

    exp_t exp_q[$];
    int   n_assert = 0;
    int   n_fail   = 0;

    shift_reg_sahr #(.WIDTH(8), .RESET_VAL(8'h00)) dut (
        .clk         (clk),
        .rst         (rst),
        .en          (en),
        .clr         (clr),
        .mode        (mode),
        .d           (d),
        .ser_in_msb  (ser_in_msb),
        .ser_in_lsb  (ser_in_lsb),
        .start       (start),
        .amount      (amount),
        .q           (q),
        .ser_out_msb (ser_out_msb),
        .ser_out_lsb (ser_out_lsb),
        .busy        (busy),
        .done        (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    // Pop the oldest expectation and compare it with the DUT outputs.
    task automatic check_head();
        exp_t e;
        n_assert++;
        assert (exp_q.size() != 0)
        else begin
            n_fail++;
            $error("FAIL scoreboard_empty: observed 0 entries expected >0");
            return;
        end
        e = exp_q.pop_front();
        n_assert++;
        assert (q === e.q)
        else begin
            n_fail++;
            $error("FAIL %s q: observed %h expected %h", e.tag, q, e.q);
        end
        n_assert++;
        assert (busy === e.busy)
        else begin
            n_fail++;
            $error("FAIL %s busy: observed %b expected %b", e.tag, busy, e.busy);
        end
        n_assert++;
        assert (done === e.done)
        else begin
            n_fail++;
            $error("FAIL %s done: observed %b expected %b", e.tag, done, e.done);
        end
        n_assert++;
        assert ({ser_out_msb, ser_out_lsb} === {e.q[7], e.q[0]})
        else begin
            n_fail++;
            $error("FAIL %s ser_out: observed %b%b expected %b%b", e.tag,
                   ser_out_msb, ser_out_lsb, e.q[7], e.q[0]);
        end
    endtask

    // Queue the expected post-edge state, take one clock edge, then check.
    task automatic cyc(input string tag, input logic [7:0] eq,
                       input logic eb, input logic ed);
        exp_q.push_back('{tag, eq, eb, ed});
        @(posedge clk);
        #1;
        check_head();
    endtask

    // Check without waiting for an edge (asynchronous reset response).
    task automatic check_now(input string tag, input logic [7:0] eq,
                             input logic eb, input logic ed);
        exp_q.push_back('{tag, eq, eb, ed});
        #1;
        check_head();
    endtask

    initial begin
        logic [7:0] v;
        int         steps;
        logic       en_k;

        rst = 1'b1; en = 1'b0; clr = 1'b0; mode = 3'b000; d = 8'h00;
        ser_in_msb = 1'b0; ser_in_lsb = 1'b0; start = 1'b0; amount = 4'd0;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        check_now("reset_state", 8'h00, 1'b0, 1'b0);

        // Async reset mid-cycle, then held across loads.
        en = 1'b1; mode = 3'b001; d = 8'h5A;
        cyc("load_5a", 8'h5A, 1'b0, 1'b0);
        mode = 3'b000;
        #2;
        rst = 1'b1;
        check_now("async_rst", 8'h00, 1'b0, 1'b0);
        mode = 3'b001; d = 8'hFF;
        repeat (3) cyc("rst_hold_load", 8'h00, 1'b0, 1'b0);
        rst = 1'b0;

        // Direct ops.
        mode = 3'b001; d = 8'hA5;
        cyc("load_a5", 8'hA5, 1'b0, 1'b0);
        mode = 3'b010; ser_in_msb = 1'b1;
        cyc("shr_msb1", 8'hD2, 1'b0, 1'b0);
        mode = 3'b011; ser_in_lsb = 1'b0;
        cyc("shl_lsb0", 8'hA4, 1'b0, 1'b0);
        mode = 3'b001; d = 8'h96;
        cyc("load_96", 8'h96, 1'b0, 1'b0);
        mode = 3'b110;
        cyc("asr_96", 8'hCB, 1'b0, 1'b0);
        en = 1'b0; mode = 3'b001; d = 8'h00;
        cyc("en0_hold", 8'hCB, 1'b0, 1'b0);
        en = 1'b1; mode = 3'b100;
        cyc("ror_cb", 8'hE5, 1'b0, 1'b0);
        mode = 3'b101;
        cyc("rol_e5", 8'hCB, 1'b0, 1'b0);
        mode = 3'b111;
        cyc("reserved_hold", 8'hCB, 1'b0, 1'b0);

        // Multi-step rotate left by 3.
        mode = 3'b001; d = 8'h81;
        cyc("load_81", 8'h81, 1'b0, 1'b0);
        start = 1'b1; mode = 3'b101; amount = 4'd3;
        cyc("rol3_start", 8'h81, 1'b1, 1'b0);
        start = 1'b0; mode = 3'b000;
        cyc("rol3_s1", 8'h03, 1'b1, 1'b0);
        cyc("rol3_s2", 8'h06, 1'b1, 1'b0);
        cyc("rol3_s3", 8'h0C, 1'b0, 1'b1);
        cyc("rol3_after", 8'h0C, 1'b0, 1'b0);

        // Clamped amount with en toggling.
        mode = 3'b001; d = 8'h3C;
        cyc("load_3c", 8'h3C, 1'b0, 1'b0);
        start = 1'b1; mode = 3'b100; amount = 4'd10;
        cyc("ror_clamp_start", 8'h3C, 1'b1, 1'b0);
        start = 1'b0; mode = 3'b000;
        v = 8'h3C;
        steps = 0;
        for (int k = 0; k < 15; k++) begin
            en_k = (k % 2 == 0);
            en = en_k;
            if (en_k) begin
                v = {v[0], v[7:1]};
                steps++;
            end
            cyc("ror_clamp_step", v, steps < 8, en_k && steps == 8);
        end
        en = 1'b1;
        cyc("ror_clamp_after", 8'h3C, 1'b0, 1'b0);

        // Abort via clr.
        mode = 3'b001; d = 8'hFF;
        cyc("load_ff_a", 8'hFF, 1'b0, 1'b0);
        start = 1'b1; mode = 3'b010; amount = 4'd5; ser_in_msb = 1'b0;
        cyc("shr5_start_a", 8'hFF, 1'b1, 1'b0);
        start = 1'b0; mode = 3'b000;
        cyc("shr5_s1_a", 8'h7F, 1'b1, 1'b0);
        cyc("shr5_s2_a", 8'h3F, 1'b1, 1'b0);
        clr = 1'b1;
        cyc("abort_clr", 8'h00, 1'b0, 1'b0);
        clr = 1'b0;
        repeat (4) cyc("abort_clr_nodone", 8'h00, 1'b0, 1'b0);

        // Abort via asynchronous reset.
        mode = 3'b001; d = 8'hFF;
        cyc("load_ff_b", 8'hFF, 1'b0, 1'b0);
        start = 1'b1; mode = 3'b010; amount = 4'd5;
        cyc("shr5_start_b", 8'hFF, 1'b1, 1'b0);
        start = 1'b0; mode = 3'b000;
        cyc("shr5_s1_b", 8'h7F, 1'b1, 1'b0);
        cyc("shr5_s2_b", 8'h3F, 1'b1, 1'b0);
        #2;
        rst = 1'b1;
        check_now("abort_rst", 8'h00, 1'b0, 1'b0);
        cyc("abort_rst_held", 8'h00, 1'b0, 1'b0);
        rst = 1'b0;
        repeat (3) cyc("abort_rst_nodone", 8'h00, 1'b0, 1'b0);

        // amount=0 completes immediately.
        mode = 3'b001; d = 8'h5A;
        cyc("load_5a_b", 8'h5A, 1'b0, 1'b0);
        start = 1'b1; mode = 3'b010; amount = 4'd0;
        cyc("amt0_done", 8'h5A, 1'b0, 1'b1);
        start = 1'b0; mode = 3'b000;
        cyc("amt0_after", 8'h5A, 1'b0, 1'b0);

        // start with a non-shift mode acts as a direct op.
        start = 1'b1; mode = 3'b001; d = 8'h3C;
        cyc("start_load", 8'h3C, 1'b0, 1'b0);
        start = 1'b0; mode = 3'b000;
        cyc("start_load_after", 8'h3C, 1'b0, 1'b0);

        // start/mode/d during busy are ignored.
        start = 1'b1; mode = 3'b011; amount = 4'd2; ser_in_lsb = 1'b1;
        cyc("shl2_start", 8'h3C, 1'b1, 1'b0);
        mode = 3'b001; d = 8'h00; amount = 4'd7;
        cyc("shl2_s1_ignore", 8'h79, 1'b1, 1'b0);
        cyc("shl2_s2_ignore", 8'hF3, 1'b0, 1'b1);

        // New start accepted in the done cycle.
        start = 1'b1; mode = 3'b010; amount = 4'd1; ser_in_msb = 1'b0;
        cyc("b2b_start", 8'hF3, 1'b1, 1'b0);
        start = 1'b0; mode = 3'b000;
        cyc("b2b_s1", 8'h79, 1'b0, 1'b1);
        cyc("b2b_after", 8'h79, 1'b0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/shift_reg_sahr.md
Name: shift_reg_sahr

Overview:
- Parametrised successor to the team's single-bit D flip-flop: a WIDTH-bit universal register with parallel load, shift, rotate and arithmetic-shift modes.
- Adds a multi-step "shift by N" command with a busy/done handshake.
- Sits between datapath producers and serialisers; acts either as a plain pipeline register or as a bit-serial shifter.

Parameters:
- WIDTH, 8, register width in bits (≥2).
- RESET_VAL, 0, value of q on reset and on clr.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- en  input  1  clock enable for direct ops and run steps
- clr  input  1  synchronous clear, aborts any run
- mode  input  3  operation select (see Behaviour)
- d  input  WIDTH  parallel load data
- ser_in_msb  input  1  bit entering MSB on shift right
- ser_in_lsb  input  1  bit entering LSB on shift left
- start  input  1  begin multi-step op of type mode
- amount  input  $clog2(WIDTH+1)  step count for start
- q  output  WIDTH  register contents
- ser_out_msb  output  1  q[WIDTH-1], combinational
- ser_out_lsb  output  1  q[0], combinational
- busy  output  1  multi-step op in progress
- done  output  1  one-cycle completion pulse

Behaviour:
- Reset: rst=1 forces q=RESET_VAL, busy=0, done=0 and FSM=IDLE immediately, independent of clk.
- Priority at each rising edge: rst > clr > run step / start > direct op.
- mode encoding:
  - 000: hold
  - 001: load d
  - 010: shift right, q<={ser_in_msb,q[W-1:1]}
  - 011: shift left, q<={q[W-2:0],ser_in_lsb}
  - 100: rotate right
  - 101: rotate left
  - 110: arithmetic shift right, MSB replicated
  - 111: hold (reserved)
- Direct op (IDLE, start=0, en=1): apply mode once at the edge; q updates the following cycle. en=0 holds q.
- clr=1: q<=RESET_VAL, busy<=0, done<=0, FSM->IDLE. Any run is aborted and no done is issued.
- FSM states: IDLE, RUN.
- IDLE, start=1, mode in 010..110:
  - Latch mode, and latch amount clamped to WIDTH.
  - If the clamped amount is 0: stay IDLE, no q change, done=1 for the next cycle.
  - Otherwise: busy<=1, FSM->RUN. q is unchanged at the start edge.
- IDLE, start=1, mode in {000,001,111}: treat as a direct op; no busy, no done.
- start is honoured regardless of en.
- RUN:
  - Each edge with en=1 applies the latched op once and decrements the remaining count.
  - en=0 stalls: no change to q or the count.
  - The edge that applies the last step sets busy<=0, done<=1 (a single cycle), FSM->IDLE.
  - An N-step op therefore completes N enabled edges after the start edge.
- During RUN: start, mode and d are ignored; ser_in_* are sampled at every step edge.
- done is registered and clears on the cycle after it asserts.
- A new start is accepted in the same cycle that done is high.
- Rotating by WIDTH returns the original value; arithmetic shift by WIDTH yields all-sign bits.

Test Plan:
- Reset: WIDTH=8, q=0x5A, raise rst mid-cycle → q=0x00, busy=0, done=0 before the next edge; hold rst for 3 edges with load active → q stays 0x00.
- Direct ops:
  - load 0xA5 → q=0xA5.
  - mode 010 with ser_in_msb=1 → 0xD2.
  - mode 011 with ser_in_lsb=0 → 0xA4 (from 0xD2).
  - mode 110 on 0x96 → 0xCB.
  - en=0 with mode 001 → q unchanged.
- Multi-step: q=0x81, start with mode=101, amount=3, en=1 → q sequence 0x03, 0x06, 0x0C; busy high for exactly 3 cycles after the start edge; done pulses once, in the cycle after the third step edge.
- Clamp and stall: q=0x3C, start with mode=100, amount=10 (clamped to 8), en toggling 1,0,1,… → 8 steps, q returns to 0x3C, done in the cycle after the 8th enabled step edge; q frozen on every en=0 cycle.
- Abort: start with mode=010, amount=5 on 0xFF; assert clr after 2 steps → q=0x00, busy=0, done never asserts. Repeat with rst instead of clr → same result, asynchronously.
- Edge cases:
  - amount=0 → done=1 for one cycle, busy stays 0, q unchanged.
  - start with mode=001 → q=d, no done pulse.
  - start during busy → ignored; count and q trajectory unaffected.
